// File: rtl/takvim_pkg.sv
// Shared calendar definitions: field-select encoding, month numbers and
// month-length helpers used by the calendar stage.
package takvim_pkg;

   localparam logic [1:0] ALAN_GUN = 2'd0;
   localparam logic [1:0] ALAN_AY  = 2'd1;
   localparam logic [1:0] ALAN_YIL = 2'd2;

   localparam logic [3:0] OCAK    = 4'd1;
   localparam logic [3:0] SUBAT   = 4'd2;
   localparam logic [3:0] MART    = 4'd3;
   localparam logic [3:0] NISAN   = 4'd4;
   localparam logic [3:0] MAYIS   = 4'd5;
   localparam logic [3:0] HAZIRAN = 4'd6;
   localparam logic [3:0] TEMMUZ  = 4'd7;
   localparam logic [3:0] AGUSTOS = 4'd8;
   localparam logic [3:0] EYLUL   = 4'd9;
   localparam logic [3:0] EKIM    = 4'd10;
   localparam logic [3:0] KASIM   = 4'd11;
   localparam logic [3:0] ARALIK  = 4'd12;

   // Gregorian rule: every 4th year, except centuries not divisible by 400.
   function automatic logic artik_yil(input logic [11:0] yil);
      return (((yil % 12'd4) == 12'd0) && ((yil % 12'd100) != 12'd0))
             || ((yil % 12'd400) == 12'd0);
   endfunction

   function automatic logic [4:0] ay_gun_sayisi(input logic [3:0] ay,
                                                input logic [11:0] yil);
      logic [4:0] n;
      case (ay)
         NISAN, HAZIRAN, EYLUL, KASIM: n = 5'd30;
         SUBAT:                        n = artik_yil(yil) ? 5'd29 : 5'd28;
         default:                      n = 5'd31;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/takvim_ay_uzunluk.sv
// Combinational month-length lookup: number of days in (ay, yil).
module takvim_ay_uzunluk
   import takvim_pkg::*;
(
   input  logic [3:0]  ay,
   input  logic [11:0] yil,
   output logic [4:0]  gun_sayisi
);

   assign gun_sayisi = ay_gun_sayisi(ay, yil);

endmodule

// File: rtl/takvim_sayac.sv
// Calendar stage: day/month/year counter driven by day carry/borrow pulses,
// with press-locked manual field editing while the clock is stopped.
module takvim_sayac
   import takvim_pkg::*;
#(
   parameter logic [11:0] YIL_MIN   = 12'd2000,
   parameter logic [11:0] YIL_MAX   = 12'd2099,
   parameter logic [11:0] YIL_RESET = 12'd2024,
   parameter logic [3:0]  AY_RESET  = 4'd1,
   parameter logic [4:0]  GUN_RESET = 5'd1
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        gun_arttir,
   input  logic        gun_azalt,
   input  logic        stop,
   input  logic        arttir_buton,
   input  logic        azalt_buton,
   input  logic        secim_buton,
   output logic [4:0]  gun,
   output logic [3:0]  ay,
   output logic [11:0] yil,
   output logic [1:0]  alan
);

   logic        kilit, kilit_d;
   logic [4:0]  gun_d;
   logic [3:0]  ay_d;
   logic [11:0] yil_d;
   logic [1:0]  alan_d;
   logic [3:0]  aday_ay;
   logic [11:0] aday_yil;
   logic [4:0]  uzun_simdi, uzun_aday;
   logic [2:0]  butonlar;
   logic        ileri, geri, darbe_var, tek_buton, uygun, eylem;

   assign butonlar  = {arttir_buton, azalt_buton, secim_buton};
   assign ileri     = gun_arttir & ~gun_azalt;
   assign geri      = gun_azalt & ~gun_arttir;
   assign darbe_var = gun_arttir | gun_azalt;
   assign tek_buton = (butonlar == 3'b100) || (butonlar == 3'b010) || (butonlar == 3'b001);
   assign uygun     = stop & ~kilit & tek_buton;
   // Any pulse input in the same cycle pre-empts the edit; the press is still consumed.
   assign eylem     = uygun & ~darbe_var;

   takvim_ay_uzunluk u_uzun_simdi (
      .ay         (ay),
      .yil        (yil),
      .gun_sayisi (uzun_simdi)
   );

   takvim_ay_uzunluk u_uzun_aday (
      .ay         (aday_ay),
      .yil        (aday_yil),
      .gun_sayisi (uzun_aday)
   );

   // Candidate month/year for a borrow across a month boundary or a manual AY/YIL edit.
   // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      aday_ay  = ay;
      aday_yil = yil;
      if (geri && (gun == 5'd1)) begin
         if (ay == OCAK) begin
            aday_ay  = ARALIK;
            aday_yil = (yil == YIL_MIN) ? YIL_MAX : yil - 12'd1;
         end else begin
            aday_ay  = ay - 4'd1;
         end
      end else if (eylem && (alan == ALAN_AY)) begin
         if (arttir_buton)
            aday_ay = (ay == ARALIK) ? OCAK : ay + 4'd1;
         else if (azalt_buton)
            aday_ay = (ay == OCAK) ? ARALIK : ay - 4'd1;
      end else if (eylem && (alan == ALAN_YIL)) begin
         if (arttir_buton)
            aday_yil = (yil == YIL_MAX) ? YIL_MIN : yil + 12'd1;
         else if (azalt_buton)
            aday_yil = (yil == YIL_MIN) ? YIL_MAX : yil - 12'd1;
      end
   end

   always_comb begin
      gun_d  = gun;
      ay_d   = ay;
      yil_d  = yil;
      alan_d = alan;
      if (ileri) begin
         if (gun < uzun_simdi) begin
            gun_d = gun + 5'd1;
         end else begin
            gun_d = 5'd1;
            if (ay == ARALIK) begin
               ay_d  = OCAK;
               yil_d = (yil == YIL_MAX) ? YIL_MIN : yil + 12'd1;
            end else begin
               ay_d  = ay + 4'd1;
            end
         end
      end else if (geri) begin
         if (gun > 5'd1) begin
            gun_d = gun - 5'd1;
         end else begin
            ay_d  = aday_ay;
            yil_d = aday_yil;
            gun_d = uzun_aday;
         end
      end else if (eylem) begin
         if (secim_buton) begin
            case (alan)
               ALAN_GUN: alan_d = ALAN_AY;
               ALAN_AY:  alan_d = ALAN_YIL;
               default:  alan_d = ALAN_GUN;
            endcase
         end else if (alan == ALAN_GUN) begin
            if (arttir_buton)
               gun_d = (gun >= uzun_simdi) ? 5'd1 : gun + 5'd1;
            else
               gun_d = (gun <= 5'd1) ? uzun_simdi : gun - 5'd1;
         end else begin
            // Month/year edits never carry; only the day is clamped to the new length.
            ay_d  = aday_ay;
            yil_d = aday_yil;
            gun_d = (gun > uzun_aday) ? uzun_aday : gun;
         end
      end
      if (!stop)
         alan_d = ALAN_GUN;
   end

   always_comb begin
      kilit_d = kilit;
      if (uygun)
         kilit_d = 1'b1;
      else if (butonlar == 3'b000)
         kilit_d = 1'b0;
   end

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gun   <= GUN_RESET;
         ay    <= AY_RESET;
         yil   <= YIL_RESET;
         alan  <= ALAN_GUN;
         kilit <= 1'b0;
      end else begin
         gun   <= gun_d;
         ay    <= ay_d;
         yil   <= yil_d;
         alan  <= alan_d;
         kilit <= kilit_d;
      end
   end

endmodule

// File: tb/tb_takvim_sayac.sv
// Self-checking bench for takvim_sayac: vector table, directed calendar
// corner cases and random stimulus against an integer date model.
module tb_takvim_sayac;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        gun_arttir = 1'b0, gun_azalt = 1'b0, stop = 1'b0;
   logic        arttir_buton = 1'b0, azalt_buton = 1'b0, secim_buton = 1'b0;
   logic [4:0]  gun;
   logic [3:0]  ay;
   logic [11:0] yil;
   logic [1:0]  alan;

   int n_checks = 0;
   int n_errors = 0;

   int m_gun, m_ay, m_yil, m_alan;
   bit m_kilit;

   typedef struct {
      bit ga, gz, st, ba, bz, bs;
      int e_gun, e_ay, e_yil, e_alan;
   } vec_t;

   vec_t tablo[13];

   takvim_sayac dut (
      .clk          (clk),
      .reset        (reset),
      .gun_arttir   (gun_arttir),
      .gun_azalt    (gun_azalt),
      .stop         (stop),
      .arttir_buton (arttir_buton),
      .azalt_buton  (azalt_buton),
      .secim_buton  (secim_buton),
      .gun          (gun),
      .ay           (ay),
      .yil          (yil),
      .alan         (alan)
   );

   always #5 clk = ~clk;

   function automatic int ndays(input int m, input int y);
      bit leap;
      leap = ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
      if (m == 2) return leap ? 29 : 28;
      if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
      return 31;
   endfunction

   task automatic model_reset();
      m_gun = 1; m_ay = 1; m_yil = 2024; m_alan = 0; m_kilit = 0;
   endtask

   task automatic next_day();
      m_gun++;
      if (m_gun > ndays(m_ay, m_yil)) begin
         m_gun = 1;
         m_ay++;
         if (m_ay > 12) begin
            m_ay = 1;
            m_yil = 2000 + (m_yil - 1999) % 100;
         end
      end
   endtask

   task automatic prev_day();
      m_gun--;
      if (m_gun == 0) begin
         m_ay--;
         if (m_ay == 0) begin
            m_ay = 12;
            m_yil = 2000 + (m_yil - 2000 + 99) % 100;
         end
         m_gun = ndays(m_ay, m_yil);
      end
   endtask

   task automatic model_step(input bit ga, gz, st, ba, bz, bs);
      int nb;
      bit elig;
      nb   = int'(ba) + int'(bz) + int'(bs);
      elig = st && !m_kilit && (nb == 1);
      if (ga && !gz) next_day();
      else if (gz && !ga) prev_day();
      else if (elig && !ga && !gz) begin
         if (bs) m_alan = (m_alan + 1) % 3;
         else if (m_alan == 0) begin
            if (ba) m_gun = m_gun % ndays(m_ay, m_yil) + 1;
            else    m_gun = (m_gun == 1) ? ndays(m_ay, m_yil) : m_gun - 1;
         end else begin
            if (m_alan == 1) m_ay = ba ? m_ay % 12 + 1 : (m_ay + 10) % 12 + 1;
            else             m_yil = 2000 + (m_yil - 2000 + (ba ? 1 : 99)) % 100;
            if (m_gun > ndays(m_ay, m_yil)) m_gun = ndays(m_ay, m_yil);
         end
      end
      if (!st) m_alan = 0;
      if (elig) m_kilit = 1;
      else if (nb == 0) m_kilit = 0;
   endtask

   task automatic chk_date(input string name, input int d, input int m, input int y, input int a);
      n_checks++;
      if (gun !== 5'(d) || ay !== 4'(m) || yil !== 12'(y) || alan !== 2'(a)) begin
         n_errors++;
         $display("FAIL %s: got %0d.%0d.%0d alan=%0d, expected %0d.%0d.%0d alan=%0d",
                  name, gun, ay, yil, alan, d, m, y, a);
      end
   endtask

   task automatic cyc(input bit ga, gz, st, ba, bz, bs);
      gun_arttir = ga; gun_azalt = gz; stop = st;
      arttir_buton = ba; azalt_buton = bz; secim_buton = bs;
      @(posedge clk);
      model_step(ga, gz, st, ba, bz, bs);
      #1;
      chk_date("cycle", m_gun, m_ay, m_yil, m_alan);
   endtask

   task automatic press(input bit ba, bz, bs);
      cyc(0, 0, 1, ba, bz, bs);
      cyc(0, 0, 1, 0, 0, 0);
   endtask

   // Reach a date through manual edits only; ends with stop=1 and alan=GUN.
   task automatic set_date(input int d, input int m, input int y);
      for (int i = 0; i < 4 && m_alan != 1; i++) press(0, 0, 1);
      for (int i = 0; i < 12 && m_ay != m; i++) press(1, 0, 0);
      press(0, 0, 1);
      for (int i = 0; i < 100 && m_yil != y; i++) press(1, 0, 0);
      press(0, 0, 1);
      for (int i = 0; i < 31 && m_gun != d; i++) press(1, 0, 0);
      chk_date("set_date", d, m, y, 0);
   endtask

   initial begin
      bit rs;
      tablo[0]  = '{1,0,0,0,0,0,  2, 1, 2024, 0};
      tablo[1]  = '{0,1,0,0,0,0,  1, 1, 2024, 0};
      tablo[2]  = '{0,1,0,0,0,0, 31,12, 2023, 0};
      tablo[3]  = '{1,0,0,0,0,0,  1, 1, 2024, 0};
      tablo[4]  = '{1,1,0,0,0,0,  1, 1, 2024, 0};
      tablo[5]  = '{0,0,1,0,0,1,  1, 1, 2024, 1};
      tablo[6]  = '{0,0,1,0,0,1,  1, 1, 2024, 1};
      tablo[7]  = '{0,0,1,0,0,0,  1, 1, 2024, 1};
      tablo[8]  = '{0,0,1,0,1,0,  1,12, 2024, 1};
      tablo[9]  = '{0,0,1,0,0,0,  1,12, 2024, 1};
      tablo[10] = '{0,0,1,1,1,0,  1,12, 2024, 1};
      tablo[11] = '{0,0,1,1,0,0,  1, 1, 2024, 1};
      tablo[12] = '{0,0,0,0,0,0,  1, 1, 2024, 0};

      model_reset();
      #12 reset = 1'b0;
      chk_date("reset_state", 1, 1, 2024, 0);

      foreach (tablo[i]) begin
         cyc(tablo[i].ga, tablo[i].gz, tablo[i].st, tablo[i].ba, tablo[i].bz, tablo[i].bs);
         chk_date($sformatf("vector%0d", i), tablo[i].e_gun, tablo[i].e_ay, tablo[i].e_yil, tablo[i].e_alan);
      end

      // Month rollover through January and a leap February.
      for (int i = 0; i < 31; i++) cyc(1, 0, 0, 0, 0, 0);
      chk_date("jan_to_feb", 1, 2, 2024, 0);
      for (int i = 0; i < 28; i++) cyc(1, 0, 0, 0, 0, 0);
      chk_date("leap_feb29", 29, 2, 2024, 0);
      cyc(1, 0, 0, 0, 0, 0);
      chk_date("feb_to_mar", 1, 3, 2024, 0);
      cyc(0, 1, 0, 0, 0, 0);
      chk_date("borrow_2024", 29, 2, 2024, 0);

      // Year range wrap both ways.
      set_date(31, 12, 2099);
      cyc(1, 0, 0, 0, 0, 0);
      chk_date("wrap_up", 1, 1, 2000, 0);
      cyc(0, 1, 0, 0, 0, 0);
      chk_date("wrap_down", 31, 12, 2099, 0);

      set_date(1, 3, 2023);
      cyc(0, 1, 0, 0, 0, 0);
      chk_date("borrow_2023", 28, 2, 2023, 0);
      set_date(1, 3, 2000);
      cyc(0, 1, 0, 0, 0, 0);
      chk_date("borrow_2000", 29, 2, 2000, 0);

      // Month/year edits clamp the day; a held button acts once.
      set_date(31, 1, 2024);
      press(0, 0, 1);
      press(1, 0, 0);
      chk_date("clamp_month", 29, 2, 2024, 1);
      press(0, 0, 1);
      for (int i = 0; i < 50; i++) cyc(0, 0, 1, 1, 0, 0);
      chk_date("clamp_year_held", 28, 2, 2025, 2);
      cyc(0, 0, 1, 0, 0, 0);

      // Day field wraps within the month, combos do nothing, stop=0 returns to GUN.
      set_date(30, 4, 2024);
      press(1, 0, 0);
      chk_date("day_wrap", 1, 4, 2024, 0);
      press(1, 1, 0);
      chk_date("combo_none", 1, 4, 2024, 0);
      press(0, 0, 1);
      cyc(0, 0, 0, 0, 0, 0);
      chk_date("stop_clears_alan", 1, 4, 2024, 0);

      // Pulse wins over a coincident press; the press is consumed.
      set_date(10, 6, 2030);
      press(0, 0, 1);
      press(0, 0, 1);
      cyc(1, 0, 1, 1, 0, 0);
      chk_date("pulse_wins", 11, 6, 2030, 2);
      cyc(0, 0, 1, 1, 0, 0);
      chk_date("press_consumed", 11, 6, 2030, 2);
      cyc(0, 0, 1, 0, 0, 0);
      cyc(0, 0, 1, 1, 0, 0);
      chk_date("year_after_repress", 11, 6, 2031, 2);

      // Async reset with the button still held: fires once after release.
      #3 reset = 1'b1;
      #1 chk_date("async_reset", 1, 1, 2024, 0);
      model_reset();
      @(posedge clk);
      #3 reset = 1'b0;
      cyc(0, 0, 1, 1, 0, 0);
      chk_date("held_after_reset", 2, 1, 2024, 0);
      cyc(0, 0, 1, 1, 0, 0);
      chk_date("held_no_repeat", 2, 1, 2024, 0);

      rs = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(31) == 0) rs = ~rs;
         cyc($urandom_range(5) == 0, $urandom_range(5) == 0, rs,
             $urandom_range(2) == 0, $urandom_range(3) == 0, $urandom_range(4) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
